// File: rtl/gv_io_frontend.sv
`default_nettype none
// ============================================================================
// Module   : gv_io_frontend
// Purpose  : GPIO front end between breakout pins and the game core.
//            - Releases the core reset through an N-stage synchroniser.
//            - Synchronises and debounces NUM_IN button pins into
//              levels and single-cycle rise pulses.
//            - Gates core outputs with chip select; fixed output-enable map.
// Options  : GV_IO_DEBOUNCE_EN - when defined, each button needs
//            DEBOUNCE_CYCLES stable synced samples before it is accepted;
//            when undefined, the synced sample is taken every edge.
// Revision : 1.0 - initial release
// ============================================================================
module gv_io_frontend #(
  parameter int NUM_GPIO        = 34,
  parameter int NUM_IN          = 4,
  parameter int RST_SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                gated_reset,
  input  logic                ncs,
  input  logic [NUM_GPIO-1:0] gpio_in,
  input  logic [NUM_GPIO-1:0] core_out,
  output logic                core_nrst,
  output logic [NUM_IN-1:0]   btn_level,
  output logic [NUM_IN-1:0]   btn_rise,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb
);

  // Button pins are inputs (oeb=1); every pin above them is a driven output.
  localparam logic [NUM_GPIO-1:0] C_OEB_MAP =
    {{(NUM_GPIO-NUM_IN){1'b0}}, {NUM_IN{1'b1}}};

  logic [RST_SYNC_STAGES-1:0] rst_sync_q;
  logic [NUM_IN-1:0]          in_meta_q;
  logic [NUM_IN-1:0]          in_sync_q;
  logic [NUM_IN-1:0]          level_q;
  logic [NUM_IN-1:0]          level_d;
  logic [NUM_IN-1:0]          level_prev_q;
  logic [NUM_IN-1:0]          rise_q;
  logic                       unused_pins;

  // Reset release synchroniser: assert asynchronously, release after N edges.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign core_nrst = rst_sync_q[RST_SYNC_STAGES-1];

  // Two-flop pin synchroniser. It lives in the core reset domain so that a
  // button held through reset release is re-sampled from a known zero.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      in_meta_q <= '0;
      in_sync_q <= '0;
    end else if (!core_nrst) begin
      in_meta_q <= '0;
      in_sync_q <= '0;
    end else begin
      in_meta_q <= gpio_in[NUM_IN-1:0];
      in_sync_q <= in_meta_q;
    end
  end

`ifdef GV_IO_DEBOUNCE_EN
  localparam int               CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < NUM_IN; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_d;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    always_comb begin
      cnt_d = '0;
      lvl_d = level_q[i];
      if (in_sync_q[i] == level_q[i]) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_LAST) begin
        lvl_d = in_sync_q[i];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Counter register; partial counts are discarded while the core is in reset.
    always_ff @(posedge clk or negedge gated_reset) begin
      if (!gated_reset) begin
        cnt_q <= '0;
      end else if (!core_nrst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign level_d[i] = lvl_d;
  end : g_debounce
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign level_d = in_sync_q;
`endif

  // Accepted level plus a one-cycle-delayed copy used to build the rise pulse.
  always_ff @(posedge clk or negedge gated_reset) begin
    if (!gated_reset) begin
      level_q      <= '0;
      level_prev_q <= '0;
      rise_q       <= '0;
    end else if (!core_nrst) begin
      level_q      <= '0;
      level_prev_q <= '0;
      rise_q       <= '0;
    end else begin
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;

  // Core outputs reach the pins only while the chip is selected; button pins stay low.
  always_comb begin
    gpio_out             = ncs ? '0 : core_out;
    gpio_out[NUM_IN-1:0] = '0;
  end

  assign gpio_oeb = C_OEB_MAP;

  // Non-button pin inputs and the core's button-pin outputs have no function here.
  assign unused_pins = ^{gpio_in[NUM_GPIO-1:NUM_IN], core_out[NUM_IN-1:0]};

endmodule : gv_io_frontend
`default_nettype wire
